// File: rtl/sha1_msg_feeder_pkg.sv
// Shared types and constants for the SHA1 message feeder.
// Holds the feeder FSM state encoding and the message-RAM address layout.
package sha1_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } feeder_state_t;

    localparam int RAM_ADDR_W   = 12;
    localparam int CHAN_FIELD_W = 6;
    localparam int BLK_IDX_W    = 6;
    localparam int RES_W        = 32;

    // Message RAM address: channel in the upper field, block index in the lower one.
    function automatic logic [RAM_ADDR_W-1:0] ram_addr(
        input logic [CHAN_FIELD_W-1:0] chan,
        input logic [BLK_IDX_W-1:0]    idx
    );
        return {chan, idx};
    endfunction

endpackage

// File: rtl/sha1_msg_feeder_if.sv
// Host-facing streams of the SHA1 message feeder: block beats in, result words out.
//
// Handshake: a beat transfers on a rising clock edge where valid and ready are
// both high. The source keeps valid and its payload stable until that edge; the
// sink may raise or drop ready freely, and ready never depends on valid.
interface sha1_msg_feeder_if #(
    parameter int MSG_DATA_WIDTH = 512,
    parameter int TAG_DATA_WIDTH = 14,
    parameter int MSG_LEN_WIDTH  = 6
);
    import sha1_feeder_pkg::*;

    logic                      s_msg_valid;
    logic                      s_msg_ready;
    logic [MSG_DATA_WIDTH-1:0] s_msg_data;
    logic                      s_msg_sop;
    logic                      s_msg_eop;
    logic [MSG_LEN_WIDTH-1:0]  s_msg_len;
    logic [TAG_DATA_WIDTH-1:0] s_msg_tag;

    logic                      m_res_valid;
    logic                      m_res_ready;
    logic [RES_W-1:0]          m_res_data;

    // Feeder side: sinks message beats, sources result words.
    modport slave (
        input  s_msg_valid, s_msg_data, s_msg_sop, s_msg_eop, s_msg_len, s_msg_tag,
        output s_msg_ready,
        output m_res_valid, m_res_data,
        input  m_res_ready
    );

    // Host side: sources message beats, sinks result words.
    modport master (
        output s_msg_valid, s_msg_data, s_msg_sop, s_msg_eop, s_msg_len, s_msg_tag,
        input  s_msg_ready,
        input  m_res_valid, m_res_data,
        output m_res_ready
    );

endinterface

// File: rtl/sha1_feeder_chan_alloc.sv
// Calculation-channel allocator for the SHA1 message feeder.
// After reset every channel is handed out once from an init counter; from then on
// channels come back only through the free-channel FIFO. A single slot (holding
// register, or a FIFO pop whose data arrives this cycle) presents the next channel.
module sha1_feeder_chan_alloc #(
    parameter int CHANNEL_NUM_TOTAL = 64,
    parameter int CHANNEL_NUM_WIDTH = $clog2(CHANNEL_NUM_TOTAL)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fifo_empty,
    input  logic [CHANNEL_NUM_WIDTH-1:0] fifo_dout,
    output logic                         fifo_rd_ena,
    output logic                         chan_valid,
    output logic [CHANNEL_NUM_WIDTH-1:0] chan_id,
    input  logic                         chan_take
);

    localparam logic [CHANNEL_NUM_WIDTH:0] INIT_END = (CHANNEL_NUM_WIDTH+1)'(CHANNEL_NUM_TOTAL);

    logic [CHANNEL_NUM_WIDTH:0]   init_cnt;
    logic                         init_done;
    logic                         hold_valid;
    logic [CHANNEL_NUM_WIDTH-1:0] hold_id;
    logic                         pop_pend;
    logic                         slot_busy;

    assign init_done = (init_cnt == INIT_END);
    // A pop in flight already owns the slot, so it blocks a second pop.
    assign slot_busy = hold_valid | pop_pend;

    assign chan_valid  = slot_busy;
    assign chan_id     = hold_valid ? hold_id : fifo_dout;
    assign fifo_rd_ena = init_done & ~fifo_empty & (~slot_busy | chan_take);

    // Slot refill: init counter first, then captured FIFO data that was not taken on arrival.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt   <= '0;
            hold_valid <= 1'b0;
            hold_id    <= '0;
            pop_pend   <= 1'b0;
        end else begin
            pop_pend <= fifo_rd_ena;
            if (!init_done && (!hold_valid || chan_take)) begin
                hold_valid <= 1'b1;
                hold_id    <= init_cnt[CHANNEL_NUM_WIDTH-1:0];
                init_cnt   <= init_cnt + 1'b1;
            end else if (pop_pend && !chan_take) begin
                hold_valid <= 1'b1;
                hold_id    <= fifo_dout;
            end else if (chan_take) begin
                hold_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sha1_msg_feeder.sv
// SHA1 message feeder: host-side front end of the SHA1 calculation top.
// Takes 512-bit block beats, binds each message to a free calculation channel,
// writes blocks to the message RAM at {channel, block_index}, counts malformed
// messages, and drains the result FIFO to a valid/ready stream.
// Optional build macro SHA1_FEEDER_STATS_EN adds msg_cnt/res_cnt counters.
module sha1_msg_feeder
    import sha1_feeder_pkg::*;
#(
    parameter int CHANNEL_NUM_TOTAL = 64,
    parameter int CHANNEL_NUM_WIDTH = $clog2(CHANNEL_NUM_TOTAL),
    parameter int TAG_DATA_WIDTH    = 14,
    parameter int MSG_DATA_WIDTH    = 512,
    parameter int MSG_LEN_WIDTH     = 6
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    sha1_msg_feeder_if.slave             host,
    output logic [MSG_DATA_WIDTH-1:0]    msg_wr_data,
    output logic                         msg_wr_ena,
    output logic                         msg_wr_sop,
    output logic [RAM_ADDR_W-1:0]        msg_wr_addr,
    output logic [MSG_LEN_WIDTH-1:0]     msg_wr_len,
    output logic [TAG_DATA_WIDTH-1:0]    msg_wr_tag,
    input  logic                         data_sq_fifo_empty,
    input  logic [CHANNEL_NUM_WIDTH-1:0] data_sq_fifo_dout,
    output logic                         data_sq_fifo_rd_ena,
    input  logic                         result_data_empty,
    input  logic [RES_W-1:0]             result_dout,
    output logic                         data_result_fifo_ren,
    output logic [15:0]                  drop_cnt
`ifdef SHA1_FEEDER_STATS_EN
    ,
    output logic [31:0]                  msg_cnt,
    output logic [31:0]                  res_cnt
`endif
);

    // ---------------- channel allocation ----------------
    logic                         chan_valid;
    logic [CHANNEL_NUM_WIDTH-1:0] chan_id;
    logic                         chan_take;

    sha1_feeder_chan_alloc #(
        .CHANNEL_NUM_TOTAL (CHANNEL_NUM_TOTAL),
        .CHANNEL_NUM_WIDTH (CHANNEL_NUM_WIDTH)
    ) u_chan_alloc (
        .clk         (sys_clk),
        .rst         (sys_rst),
        .fifo_empty  (data_sq_fifo_empty),
        .fifo_dout   (data_sq_fifo_dout),
        .fifo_rd_ena (data_sq_fifo_rd_ena),
        .chan_valid  (chan_valid),
        .chan_id     (chan_id),
        .chan_take   (chan_take)
    );

    // ---------------- message FSM ----------------
    feeder_state_t                state_q, state_d;
    logic [MSG_LEN_WIDTH-1:0]     blk_q, blk_d;
    logic [MSG_LEN_WIDTH-1:0]     cur_len;
    logic [TAG_DATA_WIDTH-1:0]    cur_tag;
    logic [CHANNEL_NUM_WIDTH-1:0] cur_chan;

    logic                         rdy;
    logic                         wr_go;
    logic                         wr_first;
    logic                         drop_go;
    logic                         done_go;
    logic [CHANNEL_NUM_WIDTH-1:0] wr_chan;
    logic [MSG_LEN_WIDTH-1:0]     wr_idx;

    assign host.s_msg_ready = rdy;
    assign wr_chan = wr_first ? chan_id : cur_chan;
    assign wr_idx  = wr_first ? '0 : blk_q;

    // Next state, beat acceptance and write/drop decisions for the current beat.
    always_comb begin
        state_d   = state_q;
        blk_d     = blk_q;
        rdy       = 1'b0;
        wr_go     = 1'b0;
        wr_first  = 1'b0;
        drop_go   = 1'b0;
        done_go   = 1'b0;
        chan_take = 1'b0;
        case (state_q)
            IDLE: begin
                rdy = chan_valid;
                if (host.s_msg_valid && chan_valid && host.s_msg_sop) begin
                    chan_take = 1'b1;
                    if (host.s_msg_len == '0) begin
                        if (host.s_msg_eop) begin
                            wr_go    = 1'b1;
                            wr_first = 1'b1;
                            done_go  = 1'b1;
                        end else begin
                            drop_go = 1'b1;
                            state_d = DROP;
                        end
                    end else if (host.s_msg_eop) begin
                        drop_go = 1'b1;
                    end else begin
                        wr_go    = 1'b1;
                        wr_first = 1'b1;
                        blk_d    = MSG_LEN_WIDTH'(1);
                        state_d  = WRITE;
                    end
                end
            end
            WRITE: begin
                rdy = 1'b1;
                if (host.s_msg_valid) begin
                    if (host.s_msg_sop) begin
                        drop_go = 1'b1;
                        state_d = host.s_msg_eop ? IDLE : DROP;
                    end else if (blk_q == cur_len) begin
                        if (host.s_msg_eop) begin
                            wr_go   = 1'b1;
                            done_go = 1'b1;
                            state_d = IDLE;
                        end else begin
                            drop_go = 1'b1;
                            state_d = DROP;
                        end
                    end else if (host.s_msg_eop) begin
                        drop_go = 1'b1;
                        state_d = IDLE;
                    end else begin
                        wr_go = 1'b1;
                        blk_d = blk_q + 1'b1;
                    end
                end
            end
            DROP: begin
                rdy = 1'b1;
                if (host.s_msg_valid && host.s_msg_eop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, block index and per-message context latched on the sop beat.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            blk_q    <= '0;
            cur_len  <= '0;
            cur_tag  <= '0;
            cur_chan <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            if (chan_take) begin
                cur_len  <= host.s_msg_len;
                cur_tag  <= host.s_msg_tag;
                cur_chan <= chan_id;
            end
        end
    end

    // Registered RAM write port; payload holds between writes.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            msg_wr_ena  <= 1'b0;
            msg_wr_sop  <= 1'b0;
            msg_wr_data <= '0;
            msg_wr_addr <= '0;
            msg_wr_len  <= '0;
            msg_wr_tag  <= '0;
        end else begin
            msg_wr_ena <= wr_go;
            msg_wr_sop <= wr_go & wr_first;
            if (wr_go) begin
                msg_wr_data <= host.s_msg_data;
                msg_wr_addr <= ram_addr(CHAN_FIELD_W'(wr_chan), BLK_IDX_W'(wr_idx));
                msg_wr_len  <= wr_first ? host.s_msg_len : cur_len;
                msg_wr_tag  <= wr_first ? host.s_msg_tag : cur_tag;
            end
        end
    end

    // Saturating count of malformed messages.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            drop_cnt <= '0;
        end else if (drop_go && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // ---------------- result path ----------------
    logic [RES_W-1:0] res_mem [2];
    logic             res_wp;
    logic             res_rp;
    logic [1:0]       res_occ;
    logic             ren_pend;
    logic             res_pop;

    // Pops still in flight reserve a slot, so the two entries never overflow.
    assign data_result_fifo_ren = ~result_data_empty & ((res_occ + {1'b0, ren_pend}) < 2'd2);
    assign host.m_res_valid     = (res_occ != 2'd0);
    assign host.m_res_data      = res_mem[res_rp];
    assign res_pop              = host.m_res_valid & host.m_res_ready;

    // Two-entry buffer: capture popped words one cycle after ren, release on handshake.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            res_mem[0] <= '0;
            res_mem[1] <= '0;
            res_wp     <= 1'b0;
            res_rp     <= 1'b0;
            res_occ    <= 2'd0;
            ren_pend   <= 1'b0;
        end else begin
            ren_pend <= data_result_fifo_ren;
            if (ren_pend) begin
                res_mem[res_wp] <= result_dout;
                res_wp          <= ~res_wp;
            end
            if (res_pop) begin
                res_rp <= ~res_rp;
            end
            case ({ren_pend, res_pop})
                2'b10:   res_occ <= res_occ + 2'd1;
                2'b01:   res_occ <= res_occ - 2'd1;
                default: res_occ <= res_occ;
            endcase
        end
    end

`ifdef SHA1_FEEDER_STATS_EN
    // Wrapping counters of completed messages and delivered results.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            msg_cnt <= '0;
            res_cnt <= '0;
        end else begin
            if (done_go) msg_cnt <= msg_cnt + 32'd1;
            if (res_pop) res_cnt <= res_cnt + 32'd1;
        end
    end
`else
    logic unused_done;
    assign unused_done = done_go;
`endif

endmodule

// File: tb/tb_sha1_msg_feeder.sv
// Directed bench for sha1_msg_feeder: message table, back-to-back, channel
// exhaustion, result drain with backpressure, and reset mid-message.
module tb_sha1_msg_feeder;

    localparam int W = 97;  // sop, len, tag, addr, data[511:480], data[31:0]

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    sha1_msg_feeder_if #(.MSG_DATA_WIDTH(512), .TAG_DATA_WIDTH(14), .MSG_LEN_WIDTH(6)) ifc ();

    logic [511:0] msg_wr_data;
    logic         msg_wr_ena;
    logic         msg_wr_sop;
    logic [11:0]  msg_wr_addr;
    logic [5:0]   msg_wr_len;
    logic [13:0]  msg_wr_tag;
    logic         sq_empty;
    logic [5:0]   sq_dout = '0;
    logic         sq_rd_ena;
    logic         res_empty;
    logic [31:0]  res_dout = '0;
    logic         res_ren;
    logic [15:0]  drop_cnt;
`ifdef SHA1_FEEDER_STATS_EN
    logic [31:0]  msg_cnt;
    logic [31:0]  res_cnt;
`endif

    sha1_msg_feeder dut (
        .sys_clk              (clk),
        .sys_rst              (rst),
        .host                 (ifc),
        .msg_wr_data          (msg_wr_data),
        .msg_wr_ena           (msg_wr_ena),
        .msg_wr_sop           (msg_wr_sop),
        .msg_wr_addr          (msg_wr_addr),
        .msg_wr_len           (msg_wr_len),
        .msg_wr_tag           (msg_wr_tag),
        .data_sq_fifo_empty   (sq_empty),
        .data_sq_fifo_dout    (sq_dout),
        .data_sq_fifo_rd_ena  (sq_rd_ena),
        .result_data_empty    (res_empty),
        .result_dout          (res_dout),
        .data_result_fifo_ren (res_ren),
        .drop_cnt             (drop_cnt)
`ifdef SHA1_FEEDER_STATS_EN
        ,
        .msg_cnt              (msg_cnt),
        .res_cnt              (res_cnt)
`endif
    );

    // ---------------- FIFO models ----------------
    logic [5:0]  free_mem [0:15];
    int          free_wr = 0;
    int          free_rd = 0;
    logic [31:0] res_mem [0:15];
    int          res_wr = 0;
    int          res_rd = 0;

    assign sq_empty  = (free_wr == free_rd);
    assign res_empty = (res_wr == res_rd);

    always @(posedge clk) begin
        if (sq_rd_ena && free_wr != free_rd) begin
            sq_dout <= free_mem[free_rd];
            free_rd <= free_rd + 1;
        end
        if (res_ren && res_wr != res_rd) begin
            res_dout <= res_mem[res_rd];
            res_rd   <= res_rd + 1;
        end
    end

    // ---------------- scoreboard ----------------
    int            total = 0;
    int            bad   = 0;
    logic [W-1:0]  exp_q [$];
    logic [31:0]   res_exp_q [$];
    int            wr_cyc_q [$];
    logic [W-1:0]  wr_got;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_word(input logic [13:0] tag, input int i);
        return {2'b10, tag, 16'(i)};
    endfunction

    task automatic expect_wr(input logic sop, input logic [5:0] len, input logic [13:0] tag,
                             input logic [11:0] addr, input logic [31:0] word);
        exp_q.push_back({sop, len, tag, addr, word, word});
    endtask

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && msg_wr_ena) begin
            wr_cyc_q.push_back(cyc);
            wr_got = {msg_wr_sop, msg_wr_len, msg_wr_tag, msg_wr_addr,
                      msg_wr_data[511:480], msg_wr_data[31:0]};
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_unexpected got=%0h exp=none", wr_got);
            end else begin
                check("wr", 128'(wr_got), 128'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic bus_idle();
        ifc.s_msg_valid = 1'b0;
        ifc.s_msg_sop   = 1'b0;
        ifc.s_msg_eop   = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after the beat is accepted.
    task automatic send_beat(input logic sop, input logic eop, input logic [5:0] len,
                             input logic [13:0] tag, input logic [31:0] word);
        int n;
        ifc.s_msg_valid = 1'b1;
        ifc.s_msg_sop   = sop;
        ifc.s_msg_eop   = eop;
        ifc.s_msg_len   = len;
        ifc.s_msg_tag   = tag;
        ifc.s_msg_data  = {16{word}};
        n = 0;
        while (!ifc.s_msg_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.s_msg_ready) begin
            total++;
            bad++;
            $display("FAIL beat_ready_timeout got=0 exp=1");
        end
        @(negedge clk);
    endtask

    task automatic drain_check(input logic [15:0] exp_drops);
        repeat (3) @(negedge clk);
        check("drop_cnt", 128'(drop_cnt), 128'(exp_drops));
        check("wr_drained", 128'(exp_q.size()), 128'(0));
    endtask

    // ---------------- message table ----------------
    typedef struct {
        logic [13:0] tag;
        logic [5:0]  len;
        int          nbeats;
        int          nwr;
        logic [15:0] drops;
        logic [5:0]  chan;
    } vec_t;

    vec_t vecs [6];

    initial begin : main
        int          ready_seen;
        int          delivered;
        int          n;
        logic        stalled;
        logic [31:0] stall_data;
        logic [31:0] w;

        // tag, len, beats (eop on last), writes expected, drop_cnt after, channel
        vecs[0] = '{14'h0015, 6'd0,  1,  1,  16'd0, 6'd0};  // single block
        vecs[1] = '{14'h0101, 6'd3,  4,  4,  16'd0, 6'd1};  // 4 blocks
        vecs[2] = '{14'h0202, 6'd3,  2,  1,  16'd1, 6'd2};  // eop before len
        vecs[3] = '{14'h00AB, 6'd2,  3,  3,  16'd1, 6'd3};  // fresh channel after drop
        vecs[4] = '{14'h0303, 6'd1,  3,  1,  16'd2, 6'd4};  // index==len without eop
        vecs[5] = '{14'h3FFF, 6'd63, 64, 64, 16'd2, 6'd5};  // longest message

        ifc.s_msg_data  = '0;
        ifc.s_msg_len   = '0;
        ifc.s_msg_tag   = '0;
        ifc.m_res_ready = 1'b0;
        bus_idle();

        // Reset state
        @(negedge clk);
        check("rst_wr_ena",  128'(msg_wr_ena), 128'(0));
        check("rst_wr_addr", 128'(msg_wr_addr), 128'(0));
        check("rst_drop",    128'(drop_cnt), 128'(0));
        check("rst_ready",   128'(ifc.s_msg_ready), 128'(0));
        check("rst_res_vld", 128'(ifc.m_res_valid), 128'(0));
        check("rst_sq_rd",   128'(sq_rd_ena), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        // Table-driven messages
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < vecs[r].nbeats; i++) begin
                if (i < vecs[r].nwr)
                    expect_wr(i == 0, vecs[r].len, vecs[r].tag, {vecs[r].chan, 6'(i)},
                              mk_word(vecs[r].tag, i));
                send_beat(i == 0, i == vecs[r].nbeats - 1, vecs[r].len, vecs[r].tag,
                          mk_word(vecs[r].tag, i));
            end
            bus_idle();
            drain_check(vecs[r].drops);
        end

        // sop inside a message: block 0 kept, message dropped, next one on channel 7
        expect_wr(1'b1, 6'd2, 14'h0077, 12'h180, mk_word(14'h0077, 0));
        send_beat(1'b1, 1'b0, 6'd2, 14'h0077, mk_word(14'h0077, 0));
        send_beat(1'b1, 1'b0, 6'd2, 14'h0077, mk_word(14'h0077, 1));
        send_beat(1'b0, 1'b1, 6'd2, 14'h0077, mk_word(14'h0077, 2));
        expect_wr(1'b1, 6'd0, 14'h0078, 12'h1C0, mk_word(14'h0078, 0));
        send_beat(1'b1, 1'b1, 6'd0, 14'h0078, mk_word(14'h0078, 0));
        // stray non-sop beat in IDLE: silently discarded
        send_beat(1'b0, 1'b1, 6'd0, 14'h0079, mk_word(14'h0079, 0));
        bus_idle();
        drain_check(16'd3);

        // Three 4-block messages back to back on channels 0,1,2
        do_reset();
        wr_cyc_q.delete();
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < 4; i++) begin
                expect_wr(i == 0, 6'd3, 14'(16'h0A0 + m), {6'(m), 6'(i)}, mk_word(14'(16'h0A0 + m), i));
                send_beat(i == 0, i == 3, 6'd3, 14'(16'h0A0 + m), mk_word(14'(16'h0A0 + m), i));
            end
        end
        bus_idle();
        drain_check(16'd0);
        check("b2b_writes", 128'(wr_cyc_q.size()), 128'(12));
        if (wr_cyc_q.size() == 12)
            check("b2b_no_gap", 128'(wr_cyc_q[11] - wr_cyc_q[0]), 128'(11));

        // Exhaust all 64 channels, then a 65th message waits for FIFO ID 7
        do_reset();
        for (int c = 0; c < 64; c++) begin
            expect_wr(1'b1, 6'd0, 14'(c), {6'(c), 6'd0}, mk_word(14'(c), 0));
            send_beat(1'b1, 1'b1, 6'd0, 14'(c), mk_word(14'(c), 0));
        end
        ifc.s_msg_valid = 1'b1;
        ifc.s_msg_sop   = 1'b1;
        ifc.s_msg_eop   = 1'b1;
        ifc.s_msg_len   = 6'd0;
        ifc.s_msg_tag   = 14'h01AB;
        ifc.s_msg_data  = {16{mk_word(14'h01AB, 0)}};
        ready_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ifc.s_msg_ready) ready_seen++;
        end
        check("exhaust_blocked", 128'(ready_seen), 128'(0));
        expect_wr(1'b1, 6'd0, 14'h01AB, 12'h1C0, mk_word(14'h01AB, 0));
        free_mem[free_wr] = 6'd7;
        free_wr = free_wr + 1;
        send_beat(1'b1, 1'b1, 6'd0, 14'h01AB, mk_word(14'h01AB, 0));
        bus_idle();
        drain_check(16'd0);

        // Result drain: 5 words, downstream ready toggling
        for (int k = 0; k < 5; k++) begin
            w = 32'hC0DE_0000 + 32'(k * 17 + 3);
            res_mem[res_wr] = w;
            res_wr = res_wr + 1;
            res_exp_q.push_back(w);
        end
        delivered  = 0;
        stalled    = 1'b0;
        stall_data = '0;
        n          = 0;
        while (delivered < 5 && n < 200) begin
            @(negedge clk);
            n++;
            ifc.m_res_ready = ~ifc.m_res_ready;
            if (stalled) begin
                check("res_hold_valid", 128'(ifc.m_res_valid), 128'(1));
                check("res_hold_data", 128'(ifc.m_res_data), 128'(stall_data));
            end
            stalled = 1'b0;
            if (ifc.m_res_valid && ifc.m_res_ready) begin
                if (res_exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL res_extra got=%0h exp=none", ifc.m_res_data);
                end else begin
                    check("res_data", 128'(ifc.m_res_data), 128'(res_exp_q.pop_front()));
                end
                delivered++;
            end else if (ifc.m_res_valid) begin
                stalled    = 1'b1;
                stall_data = ifc.m_res_data;
            end
        end
        check("res_count", 128'(delivered), 128'(5));
        ifc.m_res_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("res_idle_valid", 128'(ifc.m_res_valid), 128'(0));
        ifc.m_res_ready = 1'b0;

        // Reset in the middle of a message
        do_reset();
        send_beat(1'b1, 1'b1, 6'd1, 14'h0011, mk_word(14'h0011, 0));  // malformed, channel 0
        expect_wr(1'b1, 6'd3, 14'h003C, 12'h040, mk_word(14'h003C, 0));
        expect_wr(1'b0, 6'd3, 14'h003C, 12'h041, mk_word(14'h003C, 1));
        send_beat(1'b1, 1'b0, 6'd3, 14'h003C, mk_word(14'h003C, 0));
        send_beat(1'b0, 1'b0, 6'd3, 14'h003C, mk_word(14'h003C, 1));
        bus_idle();
        #2 rst = 1'b1;
        #1;
        check("mid_rst_wr_ena",  128'(msg_wr_ena), 128'(0));
        check("mid_rst_addr",    128'(msg_wr_addr), 128'(0));
        check("mid_rst_tag",     128'(msg_wr_tag), 128'(0));
        check("mid_rst_len",     128'(msg_wr_len), 128'(0));
        check("mid_rst_data",    128'(msg_wr_data[31:0]), 128'(0));
        check("mid_rst_drop",    128'(drop_cnt), 128'(0));
        check("mid_rst_ready",   128'(ifc.s_msg_ready), 128'(0));
        check("mid_rst_pending", 128'(exp_q.size()), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expect_wr(1'b1, 6'd0, 14'h002A, 12'h000, mk_word(14'h002A, 0));
        send_beat(1'b1, 1'b1, 6'd0, 14'h002A, mk_word(14'h002A, 0));
        bus_idle();
        drain_check(16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound
    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sha1_msg_feeder.md
Name: sha1_msg_feeder

Overview:
Host-side counterpart of the SHA1 calculation top. Accepts upstream messages as 512-bit block beats with a tag and a block count. Allocates a free calculation channel and writes each block into the message RAM at {channel, block_index}. Returns channel IDs via the free-channel FIFO and drains the 32-bit result FIFO to a downstream valid/ready stream.

Parameters:
CHANNEL_NUM_TOTAL, 64, number of calculation channels (power of 2, ≤64)
CHANNEL_NUM_WIDTH, $clog2(CHANNEL_NUM_TOTAL), channel ID width
TAG_DATA_WIDTH, 14, message tag width
MSG_DATA_WIDTH, 512, block width
MSG_LEN_WIDTH, 6, block-count field width (count minus 1)

Ports:
sys_clk  in  1  clock
sys_rst  in  1  reset, asynchronous, active-high
s_msg_valid  in  1  upstream beat valid
s_msg_ready  out  1  upstream beat accepted when valid&ready
s_msg_data  in  MSG_DATA_WIDTH  padded 512-bit block
s_msg_sop  in  1  first block of message
s_msg_eop  in  1  last block of message
s_msg_len  in  MSG_LEN_WIDTH  block count minus 1, sampled on sop beat
s_msg_tag  in  TAG_DATA_WIDTH  message tag, sampled on sop beat
msg_wr_data  out  MSG_DATA_WIDTH  RAM write data
msg_wr_ena  out  1  RAM write strobe
msg_wr_sop  out  1  first write of message
msg_wr_addr  out  12  {channel[5:0], block_index[5:0]}
msg_wr_len  out  6  latched s_msg_len, held on every write of message
msg_wr_tag  out  TAG_DATA_WIDTH  latched tag, held on every write
data_sq_fifo_empty  in  1  free-channel FIFO empty
data_sq_fifo_dout  in  CHANNEL_NUM_WIDTH  freed channel ID, valid 1 cycle after rd_ena
data_sq_fifo_rd_ena  out  1  pop freed channel
result_data_empty  in  1  result FIFO empty
result_dout  in  32  result word, valid 1 cycle after ren
data_result_fifo_ren  out  1  pop result
m_res_valid  out  1  result valid
m_res_ready  in  1  downstream ready
m_res_data  out  32  result word
drop_cnt  out  16  saturating count of malformed messages dropped

Behaviour:
- Reset values: all outputs 0; internal init counter 0; channel holding register empty; FSM IDLE.
- Channel source: after reset, channels 0..CHANNEL_NUM_TOTAL-1 are issued from an init counter in order. After all are issued, channels come only from the free-channel FIFO. rd_ena is asserted only when !empty and the holding register is empty or being consumed this cycle; dout is captured the next cycle.
- FSM IDLE: s_msg_ready=1 only if a channel is held. A sop beat latches tag, len, and channel, writes block 0 with msg_wr_sop=1, and consumes the channel. If len==0 and eop, stay IDLE; otherwise go to WRITE.
- WRITE: s_msg_ready=1. Each beat writes the next block_index, sop=0. A beat with index==len and eop returns to IDLE.
- Malformed input goes to DROP:
  - sop while in WRITE;
  - eop before index==len;
  - index==len without eop.
  The channel stays consumed. drop_cnt increments (saturates at 0xFFFF), and msg_wr_len/msg_wr_tag for that channel are left unchanged.
- DROP: s_msg_ready=1; discard beats until eop, then go to IDLE. A non-sop beat in IDLE is discarded silently.
- Write latency: msg_wr_* is registered, one cycle after the accepted beat. Max one write per cycle; back-to-back messages are supported at full rate when channels are available.
- Result path: 2-entry skid buffer. ren is asserted when !result_data_empty and occupancy plus in-flight pops is below 2. The word is captured one cycle after ren. m_res_data is held stable while valid&!ready.
- Reset mid-message: state is discarded, and the init counter re-issues all channels (the calc core is reset by the same sys_rst).

Optional Feature:
SHA1_FEEDER_STATS_EN defined: adds outputs msg_cnt[31:0] (messages fully written) and res_cnt[31:0] (results delivered downstream), both wrapping and reset to 0. Not defined: ports absent, no counters synthesized.

Decomposition:
- Package sha1_feeder_pkg: FSM state enum (IDLE, WRITE, DROP), RAM address width 12, block-index width 6, result width 32.
- One sub-module, sha1_feeder_chan_alloc: init counter, free-FIFO pop, and holding register; it presents chan_valid/chan_id/chan_take.

Test Plan:
- Reset, then a single-block message (len=0, sop&eop, tag 0x15): one write, addr 0x000, sop=1, len=0, tag 0x15.
- Three messages of 4 blocks back-to-back: channels 0,1,2; addrs 0x000–0x003, 0x040–0x043, 0x080–0x083; no idle cycles on the write side.
- Exhaust 64 channels, then present a 65th message: s_msg_ready stays 0 until FIFO pushes ID 7; the message writes at 0x1C0.
- Message with len=3 but eop on the 2nd beat: drop_cnt=1, then the next valid message proceeds on a fresh channel.
- Result FIFO with 5 words, m_res_ready toggling 1/0: all 5 words delivered in order, no loss or duplication, data stable while stalled.
- sys_rst asserted mid-message: all outputs 0 asynchronously; after release, first message uses channel 0.
